// File: rtl/record_wr_ctrl.sv
// Record-path SDRAM write controller: captures {L,R} ADC samples and writes them as 16-bit words.
// Optional build macro RECORD_WR_CTRL_MONO_EN: write only the left word of each sample.
module record_wr_ctrl #(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] REC_WORDS = 24'd960000
) (
  input  logic              clk50M,
  input  logic              reset,
  input  logic              record_start,
  input  logic              sdr_waddr_set,
  input  logic              adc_valid,
  input  logic [31:0]       adc_data,
  output logic              sdr_wr_req,
  output logic [ADDR_W-1:0] sdr_wr_addr,
  output logic [15:0]       sdr_wr_data,
  input  logic              sdr_wr_ack,
  output logic              recording,
  output logic              rec_done,
  output logic [ADDR_W-1:0] rec_len,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_WR_L = 3'd2,
    S_WR_R = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] count_d;
  logic              abort_q;
  logic              abort_now_s;
  logic              wr_fire_s;
  logic              last_word_s;
`ifdef RECORD_WR_CTRL_MONO_EN
  logic              unused_right_s;
  assign unused_right_s = ^adc_data[15:0];
`else
  logic [15:0]       right_q;
`endif

  // Next address/count after an accepted word; count saturates, address wraps.
  always_comb begin
    addr_d      = addr_q + ONE;
    count_d     = (count_q == REC_WORDS) ? count_q : (count_q + ONE);
    abort_now_s = abort_q | sdr_waddr_set;
    wr_fire_s   = sdr_wr_req & sdr_wr_ack;
    last_word_s = (count_d == REC_WORDS) | abort_now_s;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      count_q     <= {ADDR_W{1'b0}};
      abort_q     <= 1'b0;
      sdr_wr_req  <= 1'b0;
      sdr_wr_addr <= {ADDR_W{1'b0}};
      sdr_wr_data <= 16'h0000;
      recording   <= 1'b0;
      rec_done    <= 1'b0;
      rec_len     <= {ADDR_W{1'b0}};
      overrun     <= 1'b0;
`ifndef RECORD_WR_CTRL_MONO_EN
      right_q     <= 16'h0000;
`endif
    end else begin
      rec_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (record_start) begin
            addr_q    <= BASE_ADDR;
            count_q   <= {ADDR_W{1'b0}};
            abort_q   <= 1'b0;
            overrun   <= 1'b0;
            recording <= 1'b1;
            state_q   <= S_WAIT;
          end else if (sdr_waddr_set) begin
            addr_q <= BASE_ADDR;
          end
        end
        S_WAIT: begin
          if (sdr_waddr_set) begin
            rec_done  <= 1'b1;
            rec_len   <= count_q;
            recording <= 1'b0;
            state_q   <= S_DONE;
          end else if (adc_valid) begin
`ifndef RECORD_WR_CTRL_MONO_EN
            right_q     <= adc_data[15:0];
`endif
            sdr_wr_data <= adc_data[31:16];
            sdr_wr_addr <= addr_q;
            sdr_wr_req  <= 1'b1;
            state_q     <= S_WR_L;
          end
        end
        S_WR_L: begin
          if (adc_valid) overrun <= 1'b1;
          if (sdr_waddr_set) abort_q <= 1'b1;
          if (wr_fire_s) begin
            addr_q  <= addr_d;
            count_q <= count_d;
`ifdef RECORD_WR_CTRL_MONO_EN
            sdr_wr_req <= 1'b0;
            if (last_word_s) begin
              rec_done  <= 1'b1;
              rec_len   <= count_d;
              recording <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
`else
            // req stays high: the right word follows immediately.
            sdr_wr_addr <= addr_d;
            sdr_wr_data <= right_q;
            state_q     <= S_WR_R;
`endif
          end
        end
        S_WR_R: begin
          if (adc_valid) overrun <= 1'b1;
          if (sdr_waddr_set) abort_q <= 1'b1;
          if (wr_fire_s) begin
            addr_q     <= addr_d;
            count_q    <= count_d;
            sdr_wr_req <= 1'b0;
            if (last_word_s) begin
              rec_done  <= 1'b1;
              rec_len   <= count_d;
              recording <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_record_wr_ctrl.sv
// Self-checking bench for record_wr_ctrl: vector table plus scoreboard of expected SDRAM writes.
// Honours RECORD_WR_CTRL_MONO_EN to expect one word per sample.
module tb_record_wr_ctrl;

`ifdef RECORD_WR_CTRL_MONO_EN
  localparam int WPS = 1;
`else
  localparam int WPS = 2;
`endif
  localparam int REC = 4 * WPS;
  localparam logic [23:0] BASE = 24'h000000;

  logic        clk50M = 1'b0;
  logic        reset;
  logic        record_start;
  logic        sdr_waddr_set;
  logic        adc_valid;
  logic [31:0] adc_data;
  logic        sdr_wr_req;
  logic [23:0] sdr_wr_addr;
  logic [15:0] sdr_wr_data;
  logic        sdr_wr_ack;
  logic        recording;
  logic        rec_done;
  logic [23:0] rec_len;
  logic        overrun;

  record_wr_ctrl #(
    .ADDR_W(24), .BASE_ADDR(BASE), .REC_WORDS(24'(REC))
  ) dut (
    .clk50M(clk50M), .reset(reset), .record_start(record_start),
    .sdr_waddr_set(sdr_waddr_set), .adc_valid(adc_valid), .adc_data(adc_data),
    .sdr_wr_req(sdr_wr_req), .sdr_wr_addr(sdr_wr_addr), .sdr_wr_data(sdr_wr_data),
    .sdr_wr_ack(sdr_wr_ack), .recording(recording), .rec_done(rec_done),
    .rec_len(rec_len), .overrun(overrun)
  );

  always #10 clk50M = ~clk50M;

  typedef struct {
    logic [31:0] sample;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t        tbl [4];
  logic [39:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          ack_wait = 0;
  bit          ack_rand = 1'b0;
  int          widx = 0;
  int          rec_done_cnt = 0;
  bit          prev_pending = 1'b0;
  logic [39:0] prev_word = 40'd0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    exp_q.push_back({BASE + 24'(widx), d});
    widx++;
  endtask

  // One clock: choose ack, check hold and writes before the edge, then step past it.
  task automatic cycle();
    logic [39:0] e;
    if (sdr_wr_req === 1'b1 && ack_wait == 0) begin
      sdr_wr_ack = 1'b1;
    end else begin
      sdr_wr_ack = 1'b0;
      if (sdr_wr_req === 1'b1) ack_wait--;
    end
    if (prev_pending) begin
      chk("hold_req", 40'(sdr_wr_req), 40'd1);
      chk("hold_word", {sdr_wr_addr, sdr_wr_data}, prev_word);
    end
    if (sdr_wr_req === 1'b1 && sdr_wr_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {sdr_wr_addr, sdr_wr_data}, 40'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_word", {sdr_wr_addr, sdr_wr_data}, e);
      end
      ack_wait = ack_rand ? int'($urandom_range(5, 0)) : 0;
    end
    prev_pending = (sdr_wr_req === 1'b1) && !sdr_wr_ack;
    prev_word    = {sdr_wr_addr, sdr_wr_data};
    if (rec_done === 1'b1) rec_done_cnt++;
    @(posedge clk50M);
    #1;
    record_start = 1'b0;
    adc_valid    = 1'b0;
  endtask

  task automatic start_rec();
    record_start = 1'b1;
    widx = 0;
    cycle();
    chk("recording_on", 40'(recording), 40'd1);
  endtask

  task automatic send_sample(input logic [31:0] s, input bit ovr, input bit abrt);
    int guard;
    adc_valid = 1'b1;
    adc_data  = s;
    push_word(s[31:16]);
    if (WPS == 2) push_word(s[15:0]);
    cycle();
    chk("req_latency", 40'(sdr_wr_req), 40'd1);
    if (ovr) begin
      adc_valid = 1'b1;
      adc_data  = 32'hDEAD_BEEF;
    end
    if (abrt) sdr_waddr_set = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      cycle();
      sdr_waddr_set = 1'b0;
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_done(input int len);
    chk("rec_done", 40'(rec_done), 40'd1);
    chk("rec_len", 40'(rec_len), 40'(len));
    chk("recording_off", 40'(recording), 40'd0);
    chk("req_idle", 40'(sdr_wr_req), 40'd0);
    cycle();
    chk("rec_done_pulse", 40'(rec_done), 40'd0);
  endtask

  initial begin
    tbl[0] = '{32'hAAAA_5555, 16'hAAAA, 16'h5555};
    tbl[1] = '{32'hAAAA_5556, 16'hAAAA, 16'h5556};
    tbl[2] = '{32'hAAAA_5557, 16'hAAAA, 16'h5557};
    tbl[3] = '{32'hAAAA_5558, 16'hAAAA, 16'h5558};

    reset = 1'b1; record_start = 1'b0; sdr_waddr_set = 1'b0;
    adc_valid = 1'b0; adc_data = 32'd0; sdr_wr_ack = 1'b0;
    repeat (3) @(posedge clk50M);
    #1;
    chk("reset_outs", {sdr_wr_req, recording, rec_done, overrun, sdr_wr_addr, sdr_wr_data[11:0]}, 40'd0);
    chk("reset_len", 40'(rec_len), 40'd0);
    reset = 1'b0;

    // Idle with adc_valid toggling: nothing moves.
    for (int i = 0; i < 10; i++) begin
      adc_valid = i[0];
      adc_data  = 32'h1234_0000 + 32'(i);
      cycle();
      chk("idle_quiet", {36'd0, sdr_wr_req, rec_done, recording, overrun}, 40'd0);
    end

    // Full recording from the vector table, ack always high.
    rec_done_cnt = 0;
    start_rec();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = tbl[i].sample;
      exp_q.push_back({BASE + 24'(widx), tbl[i].exp_l});
      widx++;
      if (WPS == 2) begin
        exp_q.push_back({BASE + 24'(widx), tbl[i].exp_r});
        widx++;
      end
      cycle();
      chk("tbl_latency", 40'(sdr_wr_req), 40'd1);
      for (int g = 0; g < 10 && exp_q.size() != 0; g++) cycle();
      chk("tbl_drained", 40'(exp_q.size()), 40'd0);
      if (i < 3) chk("tbl_still_rec", {38'd0, recording, rec_done}, 40'd2);
    end
    adc_valid = 1'b1;
    check_done(REC);
    chk("done_no_overrun", 40'(overrun), 40'd0);
    repeat (3) cycle();
    chk("rec_done_once", 40'(rec_done_cnt), 40'd1);

    // Random ack delays.
    ack_rand = 1'b1;
    start_rec();
    for (int i = 0; i < 4; i++) send_sample($urandom(), 1'b0, 1'b0);
    check_done(REC);
    ack_rand = 1'b0;
    ack_wait = 0;

    // Sample during WR_L is dropped and flags overrun.
    start_rec();
    send_sample(32'h1111_2222, 1'b1, 1'b0);
    chk("overrun_set", 40'(overrun), 40'd1);
    for (int i = 1; i < 4; i++) send_sample(32'h3333_4444 + 32'(i), 1'b0, 1'b0);
    chk("overrun_sticky", 40'(overrun), 40'd1);
    check_done(REC);

    // Next start clears overrun; abort during the third sample's WR_L.
    start_rec();
    chk("overrun_cleared", 40'(overrun), 40'd0);
    send_sample(32'h5A5A_0001, 1'b0, 1'b0);
    send_sample(32'h5A5A_0002, 1'b0, 1'b0);
    send_sample(32'h5A5A_0003, 1'b0, 1'b1);
    check_done(3 * WPS);

    // Restart writes from BASE_ADDR; abort from WAIT.
    start_rec();
    send_sample(32'hC0DE_F00D, 1'b0, 1'b0);
    sdr_waddr_set = 1'b1;
    cycle();
    sdr_waddr_set = 1'b0;
    check_done(WPS);

    chk("scoreboard_empty", 40'(exp_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
